cfar_peak_fifo: RTL

Downstream stage of the CFAR detector: captures every peak report (max_valid pulse with index_out/max_value), buffers the reports in a first-word-fall-through FIFO, and presents them on a valid/ready stream for the host or DMA reader. It enforces a per-frame peak budget, counts frame peaks, and keeps a sticky record of any lost reports so software can tell a truncated detection list from a complete one.

---
 rtl/cfar_pkg.sv | 13 +
 rtl/sync_fifo.sv | 60 ++++++
 rtl/cfar_peak_fifo.sv | 96 +++++++++
 3 files changed

// File: rtl/cfar_pkg.sv
// rtl/cfar_pkg.sv - shared CFAR detector constants and peak record type
package cfar_pkg;

  localparam int INPUT_WIDTH = 16;
  localparam int INDEX_WIDTH = 10;
  localparam int FRAME_BINS  = 512;

  typedef struct packed {
    logic [INDEX_WIDTH-1:0] index;
    logic [INPUT_WIDTH-1:0] value;
  } peak_rec_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - first-word-fall-through synchronous FIFO with occupancy count
module sync_fifo #(
  parameter int WIDTH = 26,
  parameter int DEPTH = 16
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_data,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [AW:0]      r_level;
  logic             w_do_push;
  logic             w_do_pop;

  // Extra pointer MSB separates full (laps differ) from empty (identical pointers).
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_level = r_level;
  assign o_data  = r_mem[r_rd_ptr[AW-1:0]];

  // A pop in the same cycle frees the slot, so a push into a full FIFO is legal then.
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  // Storage is intentionally not reset; only the pointers define valid contents.
  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + (AW+1)'(1);
        2'b01:   r_level <= r_level - (AW+1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/cfar_peak_fifo.sv
// rtl/cfar_peak_fifo.sv - peak report buffer with per-frame budget and drop accounting
module cfar_peak_fifo #(
  parameter int INPUT_WIDTH = cfar_pkg::INPUT_WIDTH,
  parameter int INDEX_WIDTH = cfar_pkg::INDEX_WIDTH,
  parameter int DEPTH       = 16,
  parameter int MAX_PEAKS   = 32
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_frame_start,
  input  logic                     i_max_valid,
  input  logic [INDEX_WIDTH-1:0]   i_index_out,
  input  logic [INPUT_WIDTH-1:0]   i_max_value,
  output logic                     o_m_valid,
  input  logic                     i_m_ready,
  output logic [INDEX_WIDTH-1:0]   o_m_index,
  output logic [INPUT_WIDTH-1:0]   o_m_value,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic [INDEX_WIDTH:0]     o_peak_count,
  output logic                     o_overflow,
  output logic                     o_limit_hit,
  output logic [7:0]               o_drop_count
);

  import cfar_pkg::*;

  localparam int                 REC_W  = INDEX_WIDTH + INPUT_WIDTH;
  localparam logic [INDEX_WIDTH:0] MAX_PK = (INDEX_WIDTH+1)'(MAX_PEAKS);

  logic                   w_full;
  logic                   w_empty;
  logic [REC_W-1:0]       w_head;
  logic                   w_pop;
  logic                   w_push;
  logic                   w_drop;
  logic                   w_budget_ok;
  logic [INDEX_WIDTH:0]   w_peak_base;
  logic [7:0]             w_drop_base;
  logic                   w_ovf_base;
  logic                   w_lim_base;

  logic [INDEX_WIDTH:0]   r_peak_count;
  logic [7:0]             r_drop_count;
  logic                   r_overflow;
  logic                   r_limit_hit;

  // frame_start clears first, so a coincident report is judged against the new frame.
  assign w_peak_base = i_frame_start ? '0   : r_peak_count;
  assign w_drop_base = i_frame_start ? 8'd0 : r_drop_count;
  assign w_ovf_base  = i_frame_start ? 1'b0 : r_overflow;
  assign w_lim_base  = i_frame_start ? 1'b0 : r_limit_hit;

  assign w_budget_ok = (w_peak_base < MAX_PK);
  assign w_pop       = ~w_empty & i_m_ready;
  assign w_push      = i_max_valid & w_budget_ok & (~w_full | w_pop);
  assign w_drop      = i_max_valid & ~w_push;

  sync_fifo #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  ({i_index_out, i_max_value}),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (o_level)
  );

  assign o_m_valid    = ~w_empty;
  assign o_m_index    = w_head[REC_W-1:INPUT_WIDTH];
  assign o_m_value    = w_head[INPUT_WIDTH-1:0];
  assign o_peak_count = r_peak_count;
  assign o_drop_count = r_drop_count;
  assign o_overflow   = r_overflow;
  assign o_limit_hit  = r_limit_hit;

  // Per-frame counters and sticky loss flags; the budget outranks fullness as drop cause.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_peak_count <= '0;
      r_drop_count <= '0;
      r_overflow   <= 1'b0;
      r_limit_hit  <= 1'b0;
    end else begin
      r_peak_count <= w_push ? w_peak_base + (INDEX_WIDTH+1)'(1) : w_peak_base;
      r_drop_count <= (w_drop && w_drop_base != 8'hFF) ? w_drop_base + 8'd1 : w_drop_base;
      r_limit_hit  <= w_lim_base | (w_drop & ~w_budget_ok);
      r_overflow   <= w_ovf_base | (w_drop & w_budget_ok);
    end
  end

endmodule
